// File: rtl/alu_uart_interface_if.sv
// Byte-level UART link plus ALU operand/result bus between the sequencer and its surroundings.
// The slave modport is the sequencer's view; master is the UART/ALU side.
interface alu_uart_interface_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic [7:0]            rx_data;
  logic                  rx_done;
  logic                  tx_done;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_overflow;
  logic                  alu_zero;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_op;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  busy;
  logic                  timeout;

  modport slave (
    input  rx_data, rx_done, tx_done, alu_result, alu_overflow, alu_zero,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, timeout
  );

  modport master (
    output rx_data, rx_done, tx_done, alu_result, alu_overflow, alu_zero,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, timeout
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects A, B, opcode bytes from the UART, holds them on the ALU, then sends result and flags bytes;
// tx_start two cycles after the opcode byte; a stalled transmitter holds the FSM, an idle receiver times out.
module alu_uart_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_uart_interface_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND_RES,
    WAIT_TX_RES,
    SEND_FLG,
    WAIT_TX_FLG
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      wd_cnt;
  logic                  wd_run;
  logic                  wd_expire;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [7:0]            res_cap;
  logic [7:0]            flg_q;
  logic [7:0]            tx_data_q;
  logic                  timeout_q;

  always_comb begin
    res_cap = '0;
    res_cap[DATA_WIDTH-1:0] = bus.alu_result;
  end

  // A byte arriving on the expiry cycle wins over the watchdog.
  assign wd_run    = (state == WAIT_B) || (state == WAIT_OP);
  assign wd_expire = wd_run && !bus.rx_done && (wd_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A: begin
        if (bus.rx_done) state_nxt = WAIT_B;
      end
      WAIT_B: begin
        if (bus.rx_done)    state_nxt = WAIT_OP;
        else if (wd_expire) state_nxt = WAIT_A;
      end
      WAIT_OP: begin
        if (bus.rx_done)    state_nxt = EXEC;
        else if (wd_expire) state_nxt = WAIT_A;
      end
      EXEC:        state_nxt = SEND_RES;
      SEND_RES:    state_nxt = WAIT_TX_RES;
      WAIT_TX_RES: begin
        if (bus.tx_done) state_nxt = SEND_FLG;
      end
      SEND_FLG:    state_nxt = WAIT_TX_FLG;
      WAIT_TX_FLG: begin
        if (bus.tx_done) state_nxt = WAIT_A;
      end
      default:     state_nxt = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      flg_q     <= '0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      timeout_q <= wd_expire;

      if (wd_run && !bus.rx_done && !wd_expire) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end

      // tx_data carries the result from EXEC onward and switches to flags only
      // once the result byte is acknowledged, so it stays stable per byte.
      case (state)
        WAIT_A: begin
          if (bus.rx_done) a_q <= bus.rx_data[DATA_WIDTH-1:0];
        end
        WAIT_B: begin
          if (bus.rx_done) b_q <= bus.rx_data[DATA_WIDTH-1:0];
        end
        WAIT_OP: begin
          if (bus.rx_done) op_q <= bus.rx_data[OP_WIDTH-1:0];
        end
        EXEC: begin
          tx_data_q <= res_cap;
          flg_q     <= {6'b0, bus.alu_overflow, bus.alu_zero};
        end
        WAIT_TX_RES: begin
          if (bus.tx_done) tx_data_q <= flg_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_op   = op_q;
  assign bus.tx_start = (state == SEND_RES) || (state == SEND_FLG);
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state != WAIT_A);
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench: stimulus pushes expected tx bytes into a queue, a negedge monitor pops them on tx_start.
module tb_alu_uart_interface;
  localparam int DW = 8;
  localparam int OW = 6;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_uart_interface_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus_if ();

  alu_uart_interface #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Reference ALU in the environment: ADD 0x20, SUB 0x22, AND 0x24.
  logic [7:0] alu_r;
  logic       alu_v;
  always_comb begin
    alu_r = 8'h00;
    alu_v = 1'b0;
    case (bus_if.alu_op)
      6'h20: begin
        alu_r = bus_if.alu_a + bus_if.alu_b;
        alu_v = (bus_if.alu_a[7] == bus_if.alu_b[7]) && (alu_r[7] != bus_if.alu_a[7]);
      end
      6'h22: begin
        alu_r = bus_if.alu_a - bus_if.alu_b;
        alu_v = (bus_if.alu_a[7] != bus_if.alu_b[7]) && (alu_r[7] != bus_if.alu_a[7]);
      end
      6'h24: alu_r = bus_if.alu_a & bus_if.alu_b;
      default: ;
    endcase
  end
  assign bus_if.alu_result   = alu_r;
  assign bus_if.alu_overflow = alu_v;
  assign bus_if.alu_zero     = (alu_r == 8'h00);

  int         checks = 0;
  int         failures = 0;
  int         timeout_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.timeout) timeout_seen++;
      if (bus_if.tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx_start actual=0x%0h required=no_byte", bus_if.tx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          chk("tx_data", {24'h0, bus_if.tx_data}, {24'h0, exp_byte});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 bus_if.rx_data = b;
    bus_if.rx_done = 1'b1;
    @(posedge clk);
    #1 bus_if.rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    repeat (3) @(posedge clk);
    #1 bus_if.tx_done = 1'b1;
    @(posedge clk);
    #1 bus_if.tx_done = 1'b0;
  endtask

  task automatic wait_tx_start(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_if.tx_start && k < 200);
  endtask

  // Called right after the opcode byte: checks latency, operands, both bytes, idle afterwards.
  task automatic finish_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int k;
    wait_tx_start(k);
    chk("op_to_tx_start_cycles", k, 2);
    chk("alu_a", {24'h0, bus_if.alu_a}, {24'h0, a});
    chk("alu_b", {24'h0, bus_if.alu_b}, {24'h0, b});
    chk("alu_op", {26'h0, bus_if.alu_op}, {26'h0, op});
    pulse_tx_done();
    wait_tx_start(k);
    chk("flags_tx_start", {31'h0, bus_if.tx_start}, 32'd1);
    chk("busy_until_last_tx_done", {31'h0, bus_if.busy}, 32'd1);
    pulse_tx_done();
    @(negedge clk);
    chk("busy_after_cmd", {31'h0, bus_if.busy}, 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] er, input logic [7:0] ef);
    exp_q.push_back(er);
    exp_q.push_back(ef);
    send_byte(a);
    @(negedge clk);
    chk("busy_after_first_byte", {31'h0, bus_if.busy}, 32'd1);
    send_byte(b);
    send_byte({2'b00, op});
    finish_cmd(a, b, op);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus_if.rx_data = 8'h00;
    bus_if.rx_done = 1'b0;
    bus_if.tx_done = 1'b0;
    #1;
    chk("reset_busy", {31'h0, bus_if.busy}, 32'd0);
    chk("reset_tx_start", {31'h0, bus_if.tx_start}, 32'd0);
    chk("reset_timeout", {31'h0, bus_if.timeout}, 32'd0);
    chk("reset_tx_data", {24'h0, bus_if.tx_data}, 32'd0);
    chk("reset_alu_a", {24'h0, bus_if.alu_a}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_cmd(8'h05, 8'h03, 6'h20, 8'h08, 8'h00);
    run_cmd(8'h80, 8'h01, 6'h22, 8'h7F, 8'h02);
    run_cmd(8'h7F, 8'h01, 6'h20, 8'h80, 8'h02);
    run_cmd(8'h0F, 8'hF0, 6'h24, 8'h00, 8'h01);

    // Idle watchdog: 100 cycles in WAIT_B discards the partial command.
    send_byte(8'h11);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_if.timeout && k < 300);
    chk("timeout_cycles", k, 101);
    chk("timeout_busy", {31'h0, bus_if.busy}, 32'd0);
    chk("timeout_keeps_a", {24'h0, bus_if.alu_a}, 32'h11);
    @(negedge clk);
    chk("timeout_single_pulse", {31'h0, bus_if.timeout}, 32'd0);
    run_cmd(8'h02, 8'h03, 6'h20, 8'h05, 8'h00);

    // Second byte lands exactly on the expiry cycle: accepted, no timeout.
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h00);
    send_byte(8'h06);
    repeat (98) @(posedge clk);
    send_byte(8'h07);
    @(negedge clk);
    chk("expiry_byte_busy", {31'h0, bus_if.busy}, 32'd1);
    chk("expiry_byte_b", {24'h0, bus_if.alu_b}, 32'h07);
    send_byte(8'h20);
    finish_cmd(8'h06, 8'h07, 6'h20);

    // Stray received byte while waiting on the transmitter is dropped.
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h02);
    send_byte(8'h80);
    send_byte(8'h01);
    send_byte(8'h22);
    wait_tx_start(k);
    send_byte(8'hAA);
    @(negedge clk);
    chk("drop_rx_keeps_a", {24'h0, bus_if.alu_a}, 32'h80);
    chk("drop_rx_no_tx_start", {31'h0, bus_if.tx_start}, 32'd0);
    pulse_tx_done();
    wait_tx_start(k);
    chk("drop_rx_flags_sent", {31'h0, bus_if.tx_start}, 32'd1);
    pulse_tx_done();
    run_cmd(8'h0F, 8'hF0, 6'h24, 8'h00, 8'h01);

    // Reset in WAIT_TX_RES: everything clears at once, nothing more is sent.
    exp_q.push_back(8'h08);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    wait_tx_start(k);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {31'h0, bus_if.busy}, 32'd0);
    chk("midreset_tx_start", {31'h0, bus_if.tx_start}, 32'd0);
    chk("midreset_tx_data", {24'h0, bus_if.tx_data}, 32'd0);
    chk("midreset_alu_a", {24'h0, bus_if.alu_a}, 32'd0);
    chk("midreset_alu_b", {24'h0, bus_if.alu_b}, 32'd0);
    chk("midreset_alu_op", {26'h0, bus_if.alu_op}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_tx_done();
    repeat (10) @(negedge clk);
    chk("postreset_idle", {31'h0, bus_if.busy}, 32'd0);
    run_cmd(8'h7F, 8'h01, 6'h20, 8'h80, 8'h02);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("timeout_pulse_count", timeout_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_time_limit actual=expired required=done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
